uart_apb_regif: RTL and testbench
=================================

UART_APB_REGIF -- requirements
Module: uart_apb_regif

Interface
REQ-001 SHALL have parameter RX_FIFO_DEPTH, default 4, power of two ≥2, sets RX holding FIFO depth.
REQ-002 SHALL have the following ports, one per line:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- psel / penable / pwrite  input  1 each  APB3 control.
- paddr  input  12  byte address; [4:2] decoded, [1:0] ignored.
- pwdata  input  32  write data.
- prdata  output  32  read data.
- pready  output  1  tied 1 (zero wait state).
- pslverr  output  1  error response, valid in access phase.
- tx_data_out  output  8  byte to transmitter.
- cfg_reg_out  output  5  frame configuration to TX/RX.
- start_tx_out  output  1  one-cycle transmit request.
- tx_busy_in / tx_done_in  input  1 each  transmitter status (done is a pulse).
- rx_done_in / parity_error_in  input  1 each  receiver pulses, qualified by rx_done_in.
- rx_data_in  input  8  received byte, valid with rx_done_in.
- irq_out  output  1  interrupt (present only with UART_REGS_IRQ_EN).

Function
REQ-003 SHALL complete a write when psel&penable&pwrite and a read when psel&penable&!pwrite; one access per such cycle.
REQ-004 SHALL decode the map: 0x00 TX_DATA RW[7:0]; 0x04 CFG RW[4:0]; 0x08 CTRL WO (bit0 start, bit1 rx_flush, reads 0); 0x0C STATUS; 0x10 RX_DATA RO; 0x14 IRQ_EN RW[5:1] (macro only).
REQ-005 STATUS SHALL be: bit0 tx_busy_in live; bit1 tx_done sticky; bit2 rx_not_empty; bit3 rx_full; bit4 parity_err sticky; bit5 rx_overrun sticky; bits 1,4,5 write-1-to-clear.
REQ-006 prdata SHALL be combinational from current state during access; unused bits 0; zero when not reading.
REQ-007 Access to an unmapped offset SHALL assert pslverr, change no state, return 0.
REQ-008 Write to TX_DATA or CTRL.start while tx_busy_in=1 SHALL assert pslverr and be ignored.
REQ-009 Accepted CTRL.start SHALL assert start_tx_out for exactly one cycle, the cycle after the access.
REQ-010 RX FIFO push SHALL occur on rx_done_in; pop SHALL occur on completed RX_DATA read, prdata showing head before the pop.
REQ-011 RX_DATA read when empty SHALL return 0, assert pslverr, not pop.
REQ-012 Push when full SHALL drop the byte and set rx_overrun; push+pop same cycle when full SHALL succeed without overrun.
REQ-013 rx_done_in with parity_error_in SHALL set parity_err and still push the byte.
REQ-014 Sticky set and W1C in the same cycle: set SHALL win.
REQ-015 CTRL.rx_flush SHALL empty the FIFO next cycle; a simultaneous push is discarded without overrun.

Reset
REQ-016 On rst_n=0 at a clk edge: TX_DATA=0, CFG=0, IRQ_EN=0, all stickies 0, FIFO empty, start_tx_out=0, irq_out=0.
REQ-017 Reset during a pending start SHALL suppress the start_tx_out pulse.

Configuration
REQ-018 With UART_REGS_IRQ_EN defined: IRQ_EN register and irq_out, registered as OR of (STATUS[5:1] & IRQ_EN[5:1]), one-cycle latency.
REQ-019 Without UART_REGS_IRQ_EN: no irq_out port, offset 0x14 is unmapped per REQ-007.

Structure
REQ-020 Package uart_regs_pkg SHALL hold register offset constants, STATUS bit indices, CFG width (5) and data width (8).
REQ-021 RX FIFO SHALL be sub-module uart_rx_fifo (push, pop, flush, data, empty, full), instantiated once.

Verification
REQ-022 Write 0x00=0x5A, write 0x08=0x1 with tx_busy_in=0 -> tx_data_out=0x5A, start_tx_out high exactly one cycle, pslverr=0.
REQ-023 tx_busy_in=1, write 0x08=0x1 -> pslverr=1, no start_tx_out pulse; tx_done_in pulse -> STATUS bit1=1; write 0x0C=0x2 -> bit1=0.
REQ-024 Push 0x11,0x22,0x33,0x44,0x55 with depth 4 -> STATUS bit3=1, bit5=1; reads 0x10 return 0x11,0x22,0x33,0x44, fifth read pslverr=1 with 0.
REQ-025 FIFO full, rx_done_in coincident with RX_DATA read -> no overrun, count stays 4; rx_done_in with parity_error_in -> STATUS bit4=1, byte stored.
REQ-026 Read 0x1C -> pslverr=1, prdata=0; with macro, IRQ_EN=0x2 and tx_done_in pulse -> irq_out=1 one cycle later, cleared after W1C of bit1.

Source files
------------

// File: rtl/uart_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_regs_pkg
// Description : Register offsets, STATUS/CTRL bit indices and widths shared
//               by the UART APB register interface and its RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_regs_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_CFG_W  = 5;

    localparam logic [11:0] c_OFS_TX_DATA = 12'h000;
    localparam logic [11:0] c_OFS_CFG     = 12'h004;
    localparam logic [11:0] c_OFS_CTRL    = 12'h008;
    localparam logic [11:0] c_OFS_STATUS  = 12'h00C;
    localparam logic [11:0] c_OFS_RX_DATA = 12'h010;
    localparam logic [11:0] c_OFS_IRQ_EN  = 12'h014;

    // Word index as seen on paddr[4:2]
    localparam logic [2:0] c_IDX_TX_DATA = c_OFS_TX_DATA[4:2];
    localparam logic [2:0] c_IDX_CFG     = c_OFS_CFG[4:2];
    localparam logic [2:0] c_IDX_CTRL    = c_OFS_CTRL[4:2];
    localparam logic [2:0] c_IDX_STATUS  = c_OFS_STATUS[4:2];
    localparam logic [2:0] c_IDX_RX_DATA = c_OFS_RX_DATA[4:2];
    localparam logic [2:0] c_IDX_IRQ_EN  = c_OFS_IRQ_EN[4:2];

    localparam int c_ST_TX_BUSY  = 0;
    localparam int c_ST_TX_DONE  = 1;
    localparam int c_ST_RX_NEMPT = 2;
    localparam int c_ST_RX_FULL  = 3;
    localparam int c_ST_PAR_ERR  = 4;
    localparam int c_ST_OVERRUN  = 5;
    localparam int c_ST_W        = 6;

    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_FLUSH = 1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Small RX holding FIFO with flush; head is visible on o_data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only legal when a pop frees a slot this cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_apb_regif.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_regif
// Description : Zero-wait-state APB3 register block for a UART (TX data, frame
//               config, control, status, RX FIFO). Macro UART_REGS_IRQ_EN adds
//               the IRQ_EN register and the irq_out port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_apb_regif
    import uart_regs_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [11:0]         paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [c_DATA_W-1:0] tx_data_out,
    output logic [c_CFG_W-1:0]  cfg_reg_out,
    output logic                start_tx_out,
    input  logic                tx_busy_in,
    input  logic                tx_done_in,
    input  logic                rx_done_in,
    input  logic                parity_error_in,
    input  logic [c_DATA_W-1:0] rx_data_in
`ifdef UART_REGS_IRQ_EN
    ,
    output logic                irq_out
`endif
);

    logic [2:0]          w_idx;
    logic                w_access;
    logic                w_wr;
    logic                w_rd;
    logic                w_mapped;
    logic                w_sel_tx;
    logic                w_sel_cfg;
    logic                w_sel_ctrl;
    logic                w_sel_status;
    logic                w_sel_rx;
    logic                w_busy_rej;
    logic                w_wr_ok;
    logic                w_flush;
    logic                w_start;
    logic                w_pop;
    logic                w_push;
    logic                w_ovr_set;
    logic                w_w1c;
    logic [c_ST_W-1:0]   w_status;
    logic [c_DATA_W-1:0] w_fifo_data;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_unused_bits;

    logic [c_DATA_W-1:0] r_tx_data;
    logic [c_CFG_W-1:0]  r_cfg;
    logic                r_tx_done;
    logic                r_par_err;
    logic                r_overrun;
    logic                r_start;

    assign w_idx        = paddr[4:2];
    assign w_access     = psel & penable;
    assign w_wr         = w_access & pwrite;
    assign w_rd         = w_access & ~pwrite;
    assign w_sel_tx     = (w_idx == c_IDX_TX_DATA);
    assign w_sel_cfg    = (w_idx == c_IDX_CFG);
    assign w_sel_ctrl   = (w_idx == c_IDX_CTRL);
    assign w_sel_status = (w_idx == c_IDX_STATUS);
    assign w_sel_rx     = (w_idx == c_IDX_RX_DATA);
    assign w_unused_bits = ^{paddr[11:5], paddr[1:0], pwdata[31:8]};

`ifdef UART_REGS_IRQ_EN
    assign w_mapped = (w_idx <= c_IDX_RX_DATA) | (w_idx == c_IDX_IRQ_EN);
`else
    assign w_mapped = (w_idx <= c_IDX_RX_DATA);
`endif

    // A rejected write is dropped entirely, including any flush bit in CTRL
    assign w_busy_rej = tx_busy_in & (w_sel_tx | (w_sel_ctrl & pwdata[c_CTRL_START]));
    assign w_wr_ok    = w_wr & w_mapped & ~w_busy_rej;
    assign w_flush    = w_wr_ok & w_sel_ctrl & pwdata[c_CTRL_FLUSH];
    assign w_start    = w_wr_ok & w_sel_ctrl & pwdata[c_CTRL_START];
    assign w_w1c      = w_wr_ok & w_sel_status;
    assign w_pop      = w_rd & w_sel_rx & ~w_fifo_empty;
    assign w_push     = rx_done_in & ~w_flush & (~w_fifo_full | w_pop);
    assign w_ovr_set  = rx_done_in & ~w_flush & w_fifo_full & ~w_pop;

    assign pready  = 1'b1;
    assign pslverr = w_access & (~w_mapped
                               | (pwrite & w_busy_rej)
                               | (~pwrite & w_sel_rx & w_fifo_empty));

    assign w_status[c_ST_TX_BUSY]  = tx_busy_in;
    assign w_status[c_ST_TX_DONE]  = r_tx_done;
    assign w_status[c_ST_RX_NEMPT] = ~w_fifo_empty;
    assign w_status[c_ST_RX_FULL]  = w_fifo_full;
    assign w_status[c_ST_PAR_ERR]  = r_par_err;
    assign w_status[c_ST_OVERRUN]  = r_overrun;

    assign tx_data_out  = r_tx_data;
    assign cfg_reg_out  = r_cfg;
    assign start_tx_out = r_start;

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (c_DATA_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (rx_data_in),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_data <= '0;
            r_cfg     <= '0;
            r_tx_done <= 1'b0;
            r_par_err <= 1'b0;
            r_overrun <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start <= w_start;
            if (w_wr_ok && w_sel_tx) begin
                r_tx_data <= pwdata[c_DATA_W-1:0];
            end
            if (w_wr_ok && w_sel_cfg) begin
                r_cfg <= pwdata[c_CFG_W-1:0];
            end
            // Sticky bits: a new event in the same cycle beats the W1C
            r_tx_done <= tx_done_in
                       | (r_tx_done & ~(w_w1c & pwdata[c_ST_TX_DONE]));
            r_par_err <= (rx_done_in & parity_error_in)
                       | (r_par_err & ~(w_w1c & pwdata[c_ST_PAR_ERR]));
            r_overrun <= w_ovr_set
                       | (r_overrun & ~(w_w1c & pwdata[c_ST_OVERRUN]));
        end
    end

`ifdef UART_REGS_IRQ_EN
    logic [c_ST_W-1:1] r_irq_en;
    logic              r_irq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= |(w_status[c_ST_W-1:1] & r_irq_en);
            if (w_wr_ok && (w_idx == c_IDX_IRQ_EN)) begin
                r_irq_en <= pwdata[c_ST_W-1:1];
            end
        end
    end

    assign irq_out = r_irq;
`endif

    always_comb begin
        prdata = '0;
        if (w_rd) begin
            case (w_idx)
                c_IDX_TX_DATA: prdata[c_DATA_W-1:0] = r_tx_data;
                c_IDX_CFG:     prdata[c_CFG_W-1:0]  = r_cfg;
                c_IDX_STATUS:  prdata[c_ST_W-1:0]   = w_status;
                c_IDX_RX_DATA: begin
                    if (!w_fifo_empty) begin
                        prdata[c_DATA_W-1:0] = w_fifo_data;
                    end
                end
`ifdef UART_REGS_IRQ_EN
                c_IDX_IRQ_EN:  prdata[c_ST_W-1:1]   = r_irq_en;
`endif
                default:       prdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_regif.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_apb_regif
// Description : Directed plus randomized APB/UART-side stimulus against a
//               queue-based register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_apb_regif;

    localparam int DEPTH = 4;
`ifdef UART_REGS_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data_out;
    logic [4:0]  cfg_reg_out;
    logic        start_tx_out;
    logic        tx_busy_in = 1'b0, tx_done_in = 1'b0;
    logic        rx_done_in = 1'b0, parity_error_in = 1'b0;
    logic [7:0]  rx_data_in = '0;
    logic        irq_obs;

    uart_apb_regif #(.RX_FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr),
        .tx_data_out     (tx_data_out),
        .cfg_reg_out     (cfg_reg_out),
        .start_tx_out    (start_tx_out),
        .tx_busy_in      (tx_busy_in),
        .tx_done_in      (tx_done_in),
        .rx_done_in      (rx_done_in),
        .parity_error_in (parity_error_in),
        .rx_data_in      (rx_data_in)
`ifdef UART_REGS_IRQ_EN
        ,
        .irq_out         (irq_obs)
`endif
    );
`ifndef UART_REGS_IRQ_EN
    assign irq_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_side = 1'b0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_tx = '0;
    logic [4:0] m_cfg = '0;
    logic [5:1] m_ien = '0;
    logic       m_done = 0, m_par = 0, m_ovr = 0, m_start = 0, m_irq = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] m_status();
        return {m_ovr, m_par, (m_q.size() == DEPTH), (m_q.size() != 0), m_done, tx_busy_in};
    endfunction

    function automatic bit m_mapped(input int idx);
        return (idx <= 4) || (IRQ && idx == 5);
    endfunction

    task automatic m_comb(output logic [31:0] rd, output logic err);
        int idx = int'(paddr[4:2]);
        rd  = '0;
        err = 1'b0;
        if (psel && penable) begin
            if (!m_mapped(idx)) err = 1'b1;
            else if (pwrite) err = tx_busy_in && (idx == 0 || (idx == 2 && pwdata[0]));
            else begin
                case (idx)
                    0: rd = 32'(m_tx);
                    1: rd = 32'(m_cfg);
                    3: rd = 32'(m_status());
                    4: if (m_q.size() == 0) err = 1'b1; else rd = 32'(m_q[0]);
                    5: rd = 32'({m_ien, 1'b0});
                    default: rd = '0;
                endcase
            end
        end
    endtask

    task automatic m_update();
        int idx = int'(paddr[4:2]);
        bit acc, wr_ok, busy_rej, pop, irq_n;
        if (!rst_n) begin
            m_q.delete();
            m_tx = '0; m_cfg = '0; m_ien = '0;
            m_done = 0; m_par = 0; m_ovr = 0; m_start = 0; m_irq = 0;
            return;
        end
        acc      = psel && penable;
        busy_rej = tx_busy_in && (idx == 0 || (idx == 2 && pwdata[0]));
        wr_ok    = acc && pwrite && m_mapped(idx) && !busy_rej;
        pop      = acc && !pwrite && idx == 4 && m_q.size() > 0;
        irq_n    = |(m_status() >> 1 & 6'(m_ien));
        m_start  = wr_ok && idx == 2 && pwdata[0];
        if (wr_ok && idx == 0) m_tx = pwdata[7:0];
        if (wr_ok && idx == 1) m_cfg = pwdata[4:0];
        if (wr_ok && idx == 5) m_ien = pwdata[5:1];
        if (wr_ok && idx == 3) begin
            if (pwdata[1]) m_done = 0;
            if (pwdata[4]) m_par = 0;
            if (pwdata[5]) m_ovr = 0;
        end
        if (tx_done_in) m_done = 1;
        if (rx_done_in && parity_error_in) m_par = 1;
        if (wr_ok && idx == 2 && pwdata[1]) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (rx_done_in) begin
                if (m_q.size() < DEPTH) m_q.push_back(rx_data_in);
                else m_ovr = 1;
            end
        end
        m_irq = IRQ ? irq_n : 1'b0;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic tick();
        logic [31:0] e_rd;
        logic        e_err;
        if (rand_side) begin
            tx_busy_in      = ($urandom_range(0, 3) == 0);
            tx_done_in      = ($urandom_range(0, 7) == 0);
            rx_done_in      = ($urandom_range(0, 2) == 0);
            parity_error_in = ($urandom_range(0, 5) == 0);
            rx_data_in      = 8'($urandom);
        end
        #1;
        m_comb(e_rd, e_err);
        check("prdata", prdata, e_rd);
        check("pready", 32'(pready), 32'd1);
        if (psel && penable) check("pslverr", 32'(pslverr), 32'(e_err));
        @(posedge clk);
        m_update();
        #1;
        check("tx_data_out", 32'(tx_data_out), 32'(m_tx));
        check("cfg_reg_out", 32'(cfg_reg_out), 32'(m_cfg));
        check("start_tx_out", 32'(start_tx_out), 32'(m_start));
        if (IRQ) check("irq_out", 32'(irq_obs), 32'(m_irq));
        @(negedge clk);
    endtask

    task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] data);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        tick();
        penable = 1;
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic rx_push(input logic [7:0] b, input bit perr);
        rx_done_in = 1; rx_data_in = b; parity_error_in = perr;
        tick();
        rx_done_in = 0; parity_error_in = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        @(negedge clk);
        idle(3);
        rst_n = 1;
        idle(1);
        for (int a = 0; a < 8; a++) apb(0, 12'(a * 4), '0);

        // Transmit path
        apb(1, 12'h000, 32'h5A);
        apb(1, 12'h004, 32'h15);
        apb(1, 12'h008, 32'h1);
        idle(2);
        tx_busy_in = 1;
        apb(1, 12'h008, 32'h1);
        apb(1, 12'h000, 32'hA5);
        idle(2);
        tx_busy_in = 0;
        tx_done_in = 1; tick(); tx_done_in = 0;
        apb(0, 12'h00C, '0);
        apb(1, 12'h00C, 32'h2);
        apb(0, 12'h00C, '0);

        // FIFO overflow and drain
        rx_push(8'h11, 0); rx_push(8'h22, 0); rx_push(8'h33, 0);
        rx_push(8'h44, 0); rx_push(8'h55, 0);
        apb(0, 12'h00C, '0);
        for (int i = 0; i < 5; i++) apb(0, 12'h010, '0);
        apb(1, 12'h00C, 32'h20);

        // Push coincident with pop while full
        for (int i = 0; i < DEPTH; i++) rx_push(8'(8'hA0 + i), 0);
        psel = 1; penable = 0; pwrite = 0; paddr = 12'h010; tick();
        penable = 1; rx_done_in = 1; rx_data_in = 8'hB7; tick();
        rx_done_in = 0; psel = 0; penable = 0;
        apb(0, 12'h00C, '0);
        for (int i = 0; i < DEPTH; i++) apb(0, 12'h010, '0);
        rx_push(8'hC3, 1);
        apb(0, 12'h00C, '0);
        apb(0, 12'h010, '0);
        // Set wins over W1C
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h00C; pwdata = 32'h12; tick();
        penable = 1; tx_done_in = 1; rx_done_in = 1; parity_error_in = 1; rx_data_in = 8'h3C; tick();
        tx_done_in = 0; rx_done_in = 0; parity_error_in = 0; psel = 0; penable = 0;
        apb(0, 12'h00C, '0);

        // Flush with a coincident push
        rx_push(8'h01, 0); rx_push(8'h02, 0);
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'h2; tick();
        penable = 1; rx_done_in = 1; rx_data_in = 8'h99; tick();
        rx_done_in = 0; psel = 0; penable = 0;
        apb(0, 12'h00C, '0);
        apb(0, 12'h010, '0);

        // Reset in the access cycle of a start
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'h1; tick();
        penable = 1; rst_n = 0; tick();
        rst_n = 1; psel = 0; penable = 0;
        idle(2);
        apb(0, 12'h1C, '0);

`ifdef UART_REGS_IRQ_EN
        apb(1, 12'h014, 32'h2);
        apb(0, 12'h014, '0);
        tx_done_in = 1; tick(); tx_done_in = 0;
        idle(2);
        apb(1, 12'h00C, 32'h2);
        idle(2);
`endif

        // Randomized traffic
        rand_side = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0; tick(); rst_n = 1;
            end
            if ($urandom_range(0, 3) == 0) idle(1);
            else if ($urandom_range(0, 1) == 0)
                apb(0, 12'($urandom_range(0, 7) * 4), '0);
            else
                apb(1, 12'($urandom_range(0, 7) * 4), $urandom);
        end
        rand_side = 0;
        tx_busy_in = 0; tx_done_in = 0; rx_done_in = 0; parity_error_in = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
